// File: rtl/ctrl_pkg.sv
// Shared state encoding, opcodes, datapath codes and control-word type for control_sequencer.
// Defining CTRL_SINGLE_STEP_EN adds the WAIT state used by single-step operation.
package ctrl_pkg;

`ifdef CTRL_SINGLE_STEP_EN
   typedef enum logic [2:0] {
      ST_INIT, ST_FETCH_L, ST_FETCH_H, ST_EXEC1, ST_EXEC2, ST_HALT, ST_WAIT
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_INIT, ST_FETCH_L, ST_FETCH_H, ST_EXEC1, ST_EXEC2, ST_HALT
   } state_t;
`endif

   localparam logic [5:0] OP_BRA  = 6'h00;
   localparam logic [5:0] OP_BNE  = 6'h01;
   localparam logic [5:0] OP_MOVL = 6'h02;
   localparam logic [5:0] OP_ADD  = 6'h03;
   localparam logic [5:0] OP_SUB  = 6'h04;
   localparam logic [5:0] OP_AND  = 6'h05;
   localparam logic [5:0] OP_ORR  = 6'h06;
   localparam logic [5:0] OP_LD   = 6'h07;
   localparam logic [5:0] OP_ST   = 6'h08;

   localparam logic [4:0] ALU_PASS_A = 5'b10000;
   localparam logic [4:0] ALU_ADD    = 5'b10100;
   localparam logic [4:0] ALU_SUB    = 5'b10110;
   localparam logic [4:0] ALU_AND    = 5'b10111;
   localparam logic [4:0] ALU_ORR    = 5'b11000;

   localparam logic [2:0] RF_FUN_ALU  = 3'b010;
   localparam logic [2:0] RF_FUN_CLR  = 3'b011;
   localparam logic [2:0] RF_FUN_LOAD = 3'b100;

   localparam logic [2:0] ARF_FUN_INC  = 3'b001;
   localparam logic [2:0] ARF_FUN_CLR  = 3'b011;
   localparam logic [2:0] ARF_FUN_LOAD = 3'b100;

   // Active-low {PC,AR,SP} enables
   localparam logic [2:0] ARF_SEL_PC   = 3'b011;
   localparam logic [2:0] ARF_SEL_AR   = 3'b101;
   localparam logic [2:0] ARF_SEL_NONE = 3'b111;

   localparam logic [1:0] ARF_OUT_PC = 2'b00;
   localparam logic [1:0] ARF_OUT_AR = 2'b10;

   typedef struct packed {
      logic [2:0] rf_outa_sel;
      logic [2:0] rf_outb_sel;
      logic [2:0] rf_fun_sel;
      logic [3:0] rf_reg_sel;
      logic [3:0] rf_scr_sel;
      logic [4:0] alu_fun_sel;
      logic       alu_wf;
      logic [1:0] arf_outc_sel;
      logic [1:0] arf_outd_sel;
      logic [2:0] arf_fun_sel;
      logic [2:0] arf_reg_sel;
      logic       ir_lh;
      logic       ir_write;
      logic       mem_wr;
      logic       mem_cs;
      logic [1:0] mux_a_sel;
      logic [1:0] mux_b_sel;
      logic       mux_c_sel;
      logic       halted;
   } ctrl_word_t;

   function automatic ctrl_word_t idle_word();
      ctrl_word_t cw;
      cw = '0;
      cw.rf_reg_sel  = 4'hF;
      cw.rf_scr_sel  = 4'hF;
      cw.arf_reg_sel = ARF_SEL_NONE;
      cw.mem_cs      = 1'b1;
      return cw;
   endfunction

   // Register index 0..3 (R1..R4) to an active-low enable with R1 on bit 3
   function automatic logic [3:0] rf_one_cold(input logic [1:0] idx);
      return ~(4'b1000 >> idx);
   endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational control-word decode from sequencer state and instruction register.
// Forces the idle word whenever i_active is low so reset is reflected without a clock.
module ctrl_decoder
   import ctrl_pkg::*;
#(
   parameter logic [5:0] HALT_OP = 6'h3F
)(
   input  logic        i_active,
   input  state_t      i_state,
   input  logic [15:0] i_ir,
   input  logic        i_zero,
   output ctrl_word_t  o_cw
);

   logic [5:0] w_op;
   logic [1:0] w_rx;
   logic [2:0] w_dst;
   logic [2:0] w_s1;
   logic [2:0] w_s2;

   assign w_op  = i_ir[15:10];
   assign w_rx  = i_ir[9:8];
   assign w_dst = i_ir[8:6];
   assign w_s1  = i_ir[5:3];
   assign w_s2  = i_ir[2:0];

   always_comb begin
      o_cw = idle_word();
      if (i_active) begin
         case (i_state)
            ST_INIT: begin
               o_cw.arf_fun_sel = ARF_FUN_CLR;
               o_cw.arf_reg_sel = ARF_SEL_PC;
               o_cw.rf_fun_sel  = RF_FUN_CLR;
               o_cw.rf_reg_sel  = 4'b0000;
            end
            ST_FETCH_L, ST_FETCH_H: begin
               o_cw.arf_outd_sel = ARF_OUT_PC;
               o_cw.mem_cs       = 1'b0;
               o_cw.ir_write     = 1'b1;
               o_cw.ir_lh        = (i_state == ST_FETCH_H);
               o_cw.arf_fun_sel  = ARF_FUN_INC;
               o_cw.arf_reg_sel  = ARF_SEL_PC;
            end
            ST_EXEC1: begin
               if (w_op != HALT_OP) begin
                  case (w_op)
                     OP_BRA, OP_BNE: begin
                        o_cw.mux_b_sel   = 2'b11;
                        o_cw.arf_fun_sel = ARF_FUN_LOAD;
                        if (w_op == OP_BRA || !i_zero)
                           o_cw.arf_reg_sel = ARF_SEL_PC;
                     end
                     OP_MOVL: begin
                        o_cw.mux_a_sel  = 2'b11;
                        o_cw.rf_fun_sel = RF_FUN_LOAD;
                        o_cw.rf_reg_sel = rf_one_cold(w_rx);
                     end
                     OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                        o_cw.rf_outa_sel = w_s1;
                        o_cw.rf_outb_sel = w_s2;
                        case (w_op)
                           OP_ADD:  o_cw.alu_fun_sel = ALU_ADD;
                           OP_SUB:  o_cw.alu_fun_sel = ALU_SUB;
                           OP_AND:  o_cw.alu_fun_sel = ALU_AND;
                           default: o_cw.alu_fun_sel = ALU_ORR;
                        endcase
                        o_cw.alu_wf     = 1'b1;
                        o_cw.mux_a_sel  = 2'b00;
                        o_cw.rf_fun_sel = RF_FUN_ALU;
                        // Destinations below 100 name no GP register: flags only
                        o_cw.rf_reg_sel = w_dst[2] ? rf_one_cold(w_dst[1:0]) : 4'hF;
                     end
                     OP_LD, OP_ST: begin
                        o_cw.mux_b_sel   = 2'b11;
                        o_cw.arf_fun_sel = ARF_FUN_LOAD;
                        o_cw.arf_reg_sel = ARF_SEL_AR;
                     end
                     default: ;
                  endcase
               end
            end
            ST_EXEC2: begin
               if (w_op == OP_LD) begin
                  o_cw.arf_outd_sel = ARF_OUT_AR;
                  o_cw.mem_cs       = 1'b0;
                  o_cw.mux_a_sel    = 2'b10;
                  o_cw.rf_fun_sel   = RF_FUN_LOAD;
                  o_cw.rf_reg_sel   = rf_one_cold(w_rx);
               end else if (w_op == OP_ST) begin
                  o_cw.rf_outa_sel  = {1'b1, w_rx};
                  o_cw.alu_fun_sel  = ALU_PASS_A;
                  o_cw.mux_c_sel    = 1'b0;
                  o_cw.arf_outd_sel = ARF_OUT_AR;
                  o_cw.mem_cs       = 1'b0;
                  o_cw.mem_wr       = 1'b1;
               end
            end
            ST_HALT: o_cw.halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/control_sequencer.sv
// Instruction sequencer: state register plus next-state logic around ctrl_decoder.
// Defining CTRL_SINGLE_STEP_EN adds the Step input and a WAIT state between instructions.
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter logic [5:0] HALT_OP = 6'h3F
)(
   input  logic        Clock,
   input  logic        Reset,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic        Step,
`endif
   input  logic [15:0] IROut,
   input  logic [3:0]  ALU_FlagsOut,
   output logic [2:0]  RF_OutASel,
   output logic [2:0]  RF_OutBSel,
   output logic [2:0]  RF_FunSel,
   output logic [3:0]  RF_RegSel,
   output logic [3:0]  RF_ScrSel,
   output logic [4:0]  ALU_FunSel,
   output logic        ALU_WF,
   output logic [1:0]  ARF_OutCSel,
   output logic [1:0]  ARF_OutDSel,
   output logic [2:0]  ARF_FunSel,
   output logic [2:0]  ARF_RegSel,
   output logic        IR_LH,
   output logic        IR_Write,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic        Halted
);

   state_t     r_state;
   state_t     w_state_next;
   ctrl_word_t w_cw;
   logic [5:0] w_op;
   logic       w_unused_flags;

   assign w_op           = IROut[15:10];
   assign w_unused_flags = ^ALU_FlagsOut[2:0];

`ifdef CTRL_SINGLE_STEP_EN
   localparam state_t INSTR_END = ST_WAIT;
   logic r_step_q;
   logic r_step_qq;
   logic w_step_rise;

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_step_q  <= 1'b0;
         r_step_qq <= 1'b0;
      end else begin
         r_step_q  <= Step;
         r_step_qq <= r_step_q;
      end
   end

   assign w_step_rise = r_step_q & ~r_step_qq;
`else
   localparam state_t INSTR_END = ST_FETCH_L;
`endif

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) r_state <= ST_INIT;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_INIT:    w_state_next = INSTR_END;
         ST_FETCH_L: w_state_next = ST_FETCH_H;
         ST_FETCH_H: w_state_next = ST_EXEC1;
         ST_EXEC1: begin
            if (w_op == HALT_OP)                    w_state_next = ST_HALT;
            else if (w_op == OP_LD || w_op == OP_ST) w_state_next = ST_EXEC2;
            else                                    w_state_next = INSTR_END;
         end
         ST_EXEC2:   w_state_next = INSTR_END;
         ST_HALT:    w_state_next = ST_HALT;
`ifdef CTRL_SINGLE_STEP_EN
         ST_WAIT:    if (w_step_rise) w_state_next = ST_FETCH_L;
`endif
         default:    w_state_next = ST_INIT;
      endcase
   end

   ctrl_decoder #(.HALT_OP(HALT_OP)) u_decoder (
      .i_active (Reset),
      .i_state  (r_state),
      .i_ir     (IROut),
      .i_zero   (ALU_FlagsOut[3]),
      .o_cw     (w_cw)
   );

   assign RF_OutASel  = w_cw.rf_outa_sel;
   assign RF_OutBSel  = w_cw.rf_outb_sel;
   assign RF_FunSel   = w_cw.rf_fun_sel;
   assign RF_RegSel   = w_cw.rf_reg_sel;
   assign RF_ScrSel   = w_cw.rf_scr_sel;
   assign ALU_FunSel  = w_cw.alu_fun_sel;
   assign ALU_WF      = w_cw.alu_wf;
   assign ARF_OutCSel = w_cw.arf_outc_sel;
   assign ARF_OutDSel = w_cw.arf_outd_sel;
   assign ARF_FunSel  = w_cw.arf_fun_sel;
   assign ARF_RegSel  = w_cw.arf_reg_sel;
   assign IR_LH       = w_cw.ir_lh;
   assign IR_Write    = w_cw.ir_write;
   assign Mem_WR      = w_cw.mem_wr;
   assign Mem_CS      = w_cw.mem_cs;
   assign MuxASel     = w_cw.mux_a_sel;
   assign MuxBSel     = w_cw.mux_b_sel;
   assign MuxCSel     = w_cw.mux_c_sel;
   assign Halted      = w_cw.halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a small datapath model (memory, IR, RF, ARF)
// follows the control outputs; expectations are queued by stimulus and checked by a monitor.
`timescale 1ns/1ps
module tb_control_sequencer;

   localparam int PERIOD = 10;

   logic        Clock;
   logic        Reset;
   logic [15:0] IROut;
   logic [3:0]  ALU_FlagsOut;
   logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
   logic [3:0]  RF_RegSel, RF_ScrSel;
   logic [4:0]  ALU_FunSel;
   logic        ALU_WF;
   logic [1:0]  ARF_OutCSel, ARF_OutDSel;
   logic [2:0]  ARF_FunSel, ARF_RegSel;
   logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
   logic [1:0]  MuxASel, MuxBSel;
   logic        MuxCSel, Halted;

   control_sequencer dut (
      .Clock(Clock), .Reset(Reset), .IROut(IROut), .ALU_FlagsOut(ALU_FlagsOut),
      .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
      .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
      .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
      .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Write(IR_Write), .Mem_WR(Mem_WR),
      .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .Halted(Halted)
   );

   initial Clock = 1'b0;
   always #(PERIOD/2) Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   // ---------------- datapath model ----------------
   logic [7:0]  mem [0:255];
   logic [7:0]  img_lo [0:15];
   logic [7:0]  img_hi [0:15];
   logic        img_en;
   logic        zflag;
   logic [15:0] ir_q, pc_q, ar_q, sp_q;
   logic [15:0] rf_q [0:3];
   logic [15:0] addr_d, mem_rd, alu_a, alu_b, alu_out, mux_a, mux_b, imm;

   assign IROut        = ir_q;
   assign ALU_FlagsOut = {zflag, 3'b000};

   always_comb begin
      imm = {8'h00, ir_q[7:0]};
      case (ARF_OutDSel)
         2'b10:   addr_d = ar_q;
         2'b11:   addr_d = sp_q;
         default: addr_d = pc_q;
      endcase
      mem_rd = {8'h00, mem[addr_d[7:0]]};
      alu_a  = RF_OutASel[2] ? rf_q[RF_OutASel[1:0]] : 16'h0000;
      alu_b  = RF_OutBSel[2] ? rf_q[RF_OutBSel[1:0]] : 16'h0000;
      case (ALU_FunSel)
         5'b10100: alu_out = alu_a + alu_b;
         5'b10110: alu_out = alu_a - alu_b;
         5'b10111: alu_out = alu_a & alu_b;
         5'b11000: alu_out = alu_a | alu_b;
         default:  alu_out = alu_a;
      endcase
      case (MuxASel)
         2'b10:   mux_a = mem_rd;
         2'b11:   mux_a = imm;
         default: mux_a = alu_out;
      endcase
      mux_b = (MuxBSel == 2'b11) ? imm : alu_out;
   end

   function automatic logic [15:0] arf_next(input logic [15:0] cur, input logic [2:0] fs,
                                            input logic [15:0] ld);
      case (fs)
         3'b001:  return cur + 16'h0001;
         3'b011:  return 16'h0000;
         3'b100:  return ld;
         default: return cur;
      endcase
   endfunction

   always @(posedge Clock) begin
      if (img_en) begin
         for (int i = 0; i < 16; i++) begin
            mem[i]      <= img_lo[i];
            mem[64 + i] <= img_hi[i];
         end
         pc_q <= 16'h1234;
         ar_q <= 16'h00EE;
         sp_q <= 16'h00F0;
         for (int i = 0; i < 4; i++) rf_q[i] <= 16'hFFFF;
      end else begin
         if (IR_Write) begin
            if (IR_LH) ir_q[15:8] <= mem_rd[7:0];
            else       ir_q[7:0]  <= mem_rd[7:0];
         end
         if (!Mem_CS && Mem_WR) mem[addr_d[7:0]] <= alu_out[7:0];
         if (!ARF_RegSel[2]) pc_q <= arf_next(pc_q, ARF_FunSel, mux_b);
         if (!ARF_RegSel[1]) ar_q <= arf_next(ar_q, ARF_FunSel, mux_b);
         if (!ARF_RegSel[0]) sp_q <= arf_next(sp_q, ARF_FunSel, mux_b);
         for (int i = 0; i < 4; i++) begin
            if (!RF_RegSel[3 - i]) begin
               case (RF_FunSel)
                  3'b011:         rf_q[i] <= 16'h0000;
                  3'b100, 3'b010: rf_q[i] <= mux_a;
                  default:        rf_q[i] <= rf_q[i];
               endcase
            end
         end
      end
   end

   // ---------------- scoreboard ----------------
   localparam int ID_ARF_FUN = 0,  ID_ARF_REG = 1,  ID_RF_FUN = 2,  ID_RF_REG = 3;
   localparam int ID_IRCTL   = 4,  ID_MEMCS   = 5,  ID_MEMWR  = 6,  ID_MUXA   = 7;
   localparam int ID_MUXB    = 8,  ID_ALUFUN  = 9,  ID_ALUWF  = 10, ID_OUTA   = 11;
   localparam int ID_OUTB    = 12, ID_OUTD    = 13, ID_HALTED = 14, ID_PC     = 15;
   localparam int ID_R1      = 16, ID_R2      = 17, ID_MEM40  = 18, ID_IDLE   = 19;

   typedef struct {
      int          cyc;
      int          id;
      logic [15:0] exp;
   } sb_t;

   sb_t  sb_q[$];
   sb_t  imm_q[$];
   event sample_now;
   bit   stim_done = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   c0;

   function automatic logic [15:0] actual(input int id);
      logic idle;
      idle = (RF_RegSel == 4'hF) && (RF_ScrSel == 4'hF) && (ARF_RegSel == 3'h7) &&
             !IR_Write && !ALU_WF && Mem_CS && !Mem_WR && !IR_LH && !MuxCSel &&
             (RF_OutASel == 3'd0) && (RF_OutBSel == 3'd0) && (RF_FunSel == 3'd0) &&
             (ALU_FunSel == 5'd0) && (ARF_OutCSel == 2'd0) && (ARF_OutDSel == 2'd0) &&
             (ARF_FunSel == 3'd0) && (MuxASel == 2'd0) && (MuxBSel == 2'd0);
      case (id)
         ID_ARF_FUN: return {13'd0, ARF_FunSel};
         ID_ARF_REG: return {13'd0, ARF_RegSel};
         ID_RF_FUN:  return {13'd0, RF_FunSel};
         ID_RF_REG:  return {12'd0, RF_RegSel};
         ID_IRCTL:   return {14'd0, IR_Write, IR_LH};
         ID_MEMCS:   return {15'd0, Mem_CS};
         ID_MEMWR:   return {15'd0, Mem_WR};
         ID_MUXA:    return {14'd0, MuxASel};
         ID_MUXB:    return {14'd0, MuxBSel};
         ID_ALUFUN:  return {11'd0, ALU_FunSel};
         ID_ALUWF:   return {15'd0, ALU_WF};
         ID_OUTA:    return {13'd0, RF_OutASel};
         ID_OUTB:    return {13'd0, RF_OutBSel};
         ID_OUTD:    return {14'd0, ARF_OutDSel};
         ID_HALTED:  return {15'd0, Halted};
         ID_PC:      return pc_q;
         ID_R1:      return rf_q[0];
         ID_R2:      return rf_q[1];
         ID_MEM40:   return {8'h00, mem[64]};
         default:    return {15'd0, idle};
      endcase
   endfunction

   function automatic string id_name(input int id);
      case (id)
         ID_ARF_FUN: return "ARF_FunSel";
         ID_ARF_REG: return "ARF_RegSel";
         ID_RF_FUN:  return "RF_FunSel";
         ID_RF_REG:  return "RF_RegSel";
         ID_IRCTL:   return "IR_Write/IR_LH";
         ID_MEMCS:   return "Mem_CS";
         ID_MEMWR:   return "Mem_WR";
         ID_MUXA:    return "MuxASel";
         ID_MUXB:    return "MuxBSel";
         ID_ALUFUN:  return "ALU_FunSel";
         ID_ALUWF:   return "ALU_WF";
         ID_OUTA:    return "RF_OutASel";
         ID_OUTB:    return "RF_OutBSel";
         ID_OUTD:    return "ARF_OutDSel";
         ID_HALTED:  return "Halted";
         ID_PC:      return "PC";
         ID_R1:      return "R1";
         ID_R2:      return "R2";
         ID_MEM40:   return "mem[40]";
         default:    return "idle_outputs";
      endcase
   endfunction

   task automatic check(input sb_t e);
      logic [15:0] act;
      act = actual(e.id);
      n_checks++;
      if (act !== e.exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", id_name(e.id), act, e.exp, cyc);
      end else begin
         $display("ok   %s = %h (cycle %0d)", id_name(e.id), act, cyc);
      end
   endtask

   // Cycle-tagged entries are compared on falling edges (multiples of PERIOD);
   // immediate entries are compared when stimulus fires sample_now between edges.
   initial begin
      sb_t e;
      forever begin
         @(negedge Clock or sample_now);
         while (imm_q.size() > 0) begin
            e = imm_q.pop_front();
            check(e);
         end
         if (($time % PERIOD) == 0) begin
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
               e = sb_q.pop_front();
               if (e.cyc < cyc) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL %s: not sampled at cycle %0d, expected %h", id_name(e.id), e.cyc, e.exp);
               end else begin
                  check(e);
               end
            end
         end
         if (stim_done) begin
            while (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               n_checks++;
               n_errors++;
               $display("FAIL %s: never sampled (cycle %0d), expected %h", id_name(e.id), e.cyc, e.exp);
            end
            $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
            $finish;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic expect_at(input int dc, input int id, input logic [15:0] v);
      sb_t e;
      e.cyc = c0 + dc;
      e.id  = id;
      e.exp = v;
      sb_q.push_back(e);
   endtask

   task automatic expect_now(input int id, input logic [15:0] v);
      sb_t e;
      e.cyc = -1;
      e.id  = id;
      e.exp = v;
      imm_q.push_back(e);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge Clock);
      #1;
   endtask

   task automatic load_img(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5,
                           input logic [7:0] h0, input logic [7:0] h1);
      for (int i = 0; i < 16; i++) begin
         img_lo[i] = 8'h00;
         img_hi[i] = 8'h00;
      end
      img_lo[0] = b0; img_lo[1] = b1; img_lo[2] = b2;
      img_lo[3] = b3; img_lo[4] = b4; img_lo[5] = b5;
      img_hi[0] = h0; img_hi[1] = h1;
   endtask

   // Hold reset (loading the image), check idle outputs, then release and check INIT.
   task automatic start_prog();
      Reset  = 1'b0;
      img_en = 1'b1;
      @(negedge Clock); #1;
      c0 = cyc;
      expect_at(1, ID_IDLE, 16'h1);
      expect_at(1, ID_HALTED, 16'h0);
      @(negedge Clock); #1;
      img_en = 1'b0;
      @(negedge Clock); #1;
      Reset = 1'b1;
      c0 = cyc;
      expect_now(ID_ARF_FUN, 16'h3);
      expect_now(ID_ARF_REG, 16'h3);
      expect_now(ID_RF_FUN, 16'h3);
      expect_now(ID_RF_REG, 16'h0);
      ->sample_now;
   endtask

   initial begin
      Reset  = 1'b0;
      img_en = 1'b0;
      zflag  = 1'b0;
      ir_q   = 16'h0000;

      // MOVL R2,#5A then HALT
      load_img(8'h5A, 8'h09, 8'h00, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00);
      start_prog();
      expect_at(1, ID_IRCTL, 16'h2);
      expect_at(1, ID_MEMCS, 16'h0);
      expect_at(1, ID_OUTD, 16'h0);
      expect_at(2, ID_IRCTL, 16'h3);
      expect_at(3, ID_MUXA, 16'h3);
      expect_at(3, ID_RF_FUN, 16'h4);
      expect_at(3, ID_RF_REG, 16'hB);
      expect_at(4, ID_R2, 16'h005A);
      expect_at(4, ID_PC, 16'h0002);
      expect_at(4, ID_IRCTL, 16'h2);
      expect_at(6, ID_IDLE, 16'h1);
      expect_at(7, ID_HALTED, 16'h1);
      wait_cyc(c0 + 8);

      // BNE #40 with Z=1 (not taken) and Z=0 (taken)
      load_img(8'h40, 8'h04, 8'h00, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hFC);
      zflag = 1'b1;
      start_prog();
      expect_at(3, ID_ARF_REG, 16'h7);
      expect_at(3, ID_MUXB, 16'h3);
      expect_at(4, ID_PC, 16'h0002);
      expect_at(7, ID_HALTED, 16'h1);
      wait_cyc(c0 + 8);
      zflag = 1'b0;
      start_prog();
      expect_at(3, ID_ARF_REG, 16'h3);
      expect_at(4, ID_PC, 16'h0040);
      expect_at(7, ID_HALTED, 16'h1);
      wait_cyc(c0 + 8);

      // ADD DST=100 S1=101 S2=110, ORR DST=011 (write suppressed), HALT
      load_img(8'h2E, 8'h0D, 8'hEE, 8'h18, 8'h00, 8'hFC, 8'h00, 8'h00);
      start_prog();
      expect_at(3, ID_ALUFUN, 16'h14);
      expect_at(3, ID_ALUWF, 16'h1);
      expect_at(3, ID_RF_REG, 16'h7);
      expect_at(3, ID_OUTA, 16'h5);
      expect_at(3, ID_OUTB, 16'h6);
      expect_at(3, ID_RF_FUN, 16'h2);
      expect_at(6, ID_ALUFUN, 16'h18);
      expect_at(6, ID_RF_REG, 16'hF);
      expect_at(6, ID_ALUWF, 16'h1);
      expect_at(10, ID_HALTED, 16'h1);
      wait_cyc(c0 + 11);

      // HALT immediately; stays halted and idle; async reset clears Halted
      load_img(8'h00, 8'hFC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      start_prog();
      expect_at(3, ID_IDLE, 16'h1);
      expect_at(3, ID_HALTED, 16'h0);
      for (int k = 4; k <= 14; k++) begin
         expect_at(k, ID_HALTED, 16'h1);
         expect_at(k, ID_IDLE, 16'h1);
      end
      expect_at(14, ID_PC, 16'h0002);
      wait_cyc(c0 + 14);
      Reset = 1'b0;
      expect_now(ID_HALTED, 16'h0);
      expect_now(ID_IDLE, 16'h1);
      ->sample_now;

      // MOVL R1,#A7 ; ST R1,#40 ; HALT
      load_img(8'hA7, 8'h08, 8'h40, 8'h20, 8'h00, 8'hFC, 8'h11, 8'h00);
      start_prog();
      expect_at(6, ID_ARF_REG, 16'h5);
      expect_at(6, ID_MUXB, 16'h3);
      expect_at(7, ID_MEMWR, 16'h1);
      expect_at(7, ID_MEMCS, 16'h0);
      expect_at(7, ID_OUTD, 16'h2);
      expect_at(8, ID_MEM40, 16'h00A7);
      expect_at(8, ID_R1, 16'h00A7);
      expect_at(11, ID_HALTED, 16'h1);
      wait_cyc(c0 + 12);

      // Same program, reset dropped during ST EXEC2: no write may land
      start_prog();
      expect_at(7, ID_MEMWR, 16'h1);
      wait_cyc(c0 + 7);
      Reset = 1'b0;
      expect_now(ID_MEMWR, 16'h0);
      expect_now(ID_MEMCS, 16'h1);
      expect_now(ID_IDLE, 16'h1);
      expect_now(ID_HALTED, 16'h0);
      ->sample_now;
      c0 = cyc;
      expect_at(3, ID_MEM40, 16'h0011);
      expect_at(3, ID_IDLE, 16'h1);
      wait_cyc(c0 + 4);

      for (int i = 0; i < 40 && sb_q.size() > 0; i++) @(negedge Clock);
      #1;
      stim_done = 1'b1;
      ->sample_now;
   end

endmodule
